lfsr_led_sequencer: RTL and testbench

Parametrised LFSR-paced LED driver for the board-level demo tops. A maximal-length XNOR LFSR of configurable width produces a periodic one-cycle tick, which advances a toggle bit, a chase position and a tick counter. A mode input then maps one of these onto `NUM_CH` LED outputs. It replaces the fixed 22-bit, 4-LED toggle/demux pairing with a generic block that has multiple display modes and synchronised switch inputs.

---
 rtl/lfsr_pkg.sv | 59 +++++
 rtl/lfsr_led_sequencer_if.sv | 25 ++
 rtl/lfsr_xnor.sv | 47 ++++
 rtl/lfsr_led_sequencer.sv | 99 +++++++++
 tb/tb_lfsr_led_sequencer.sv | 185 ++++++++++++++++++
 5 files changed

// File: rtl/lfsr_pkg.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_pkg
// Description : Shared definitions for the LFSR LED sequencer: maximal-length
//               XNOR tap table (widths 3..32) and display-mode encodings.
// Ports       : none (package)
// Revision    : 1.0 - initial release
// ============================================================================
package lfsr_pkg;

    localparam logic [1:0] MODE_SINGLE = 2'b00;
    localparam logic [1:0] MODE_ALL    = 2'b01;
    localparam logic [1:0] MODE_CHASE  = 2'b10;
    localparam logic [1:0] MODE_COUNT  = 2'b11;

    // Tap n of the classic maximal-length table maps to register bit n-1.
    // With XNOR feedback the all-ones word is the lockup state, so an
    // all-zeros reset value sits on the maximal cycle.
    function automatic logic [31:0] lfsr_taps(input int width);
        logic [31:0] mask;
        mask = 32'h0;
        case (width)
            3:       mask = 32'h0000_0006;
            4:       mask = 32'h0000_000C;
            5:       mask = 32'h0000_0014;
            6:       mask = 32'h0000_0030;
            7:       mask = 32'h0000_0060;
            8:       mask = 32'h0000_00B8;
            9:       mask = 32'h0000_0110;
            10:      mask = 32'h0000_0240;
            11:      mask = 32'h0000_0500;
            12:      mask = 32'h0000_0829;
            13:      mask = 32'h0000_100D;
            14:      mask = 32'h0000_2015;
            15:      mask = 32'h0000_6000;
            16:      mask = 32'h0000_D008;
            17:      mask = 32'h0001_2000;
            18:      mask = 32'h0002_0400;
            19:      mask = 32'h0004_0023;
            20:      mask = 32'h0009_0000;
            21:      mask = 32'h0014_0000;
            22:      mask = 32'h0030_0000;
            23:      mask = 32'h0042_0000;
            24:      mask = 32'h00E1_0000;
            25:      mask = 32'h0120_0000;
            26:      mask = 32'h0200_0023;
            27:      mask = 32'h0400_0013;
            28:      mask = 32'h0900_0000;
            29:      mask = 32'h1400_0000;
            30:      mask = 32'h2000_0029;
            31:      mask = 32'h4800_0000;
            32:      mask = 32'h8020_0003;
            default: mask = 32'h0;
        endcase
        return mask;
    endfunction

endpackage : lfsr_pkg
`default_nettype wire

// File: rtl/lfsr_led_sequencer_if.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_led_sequencer_if
// Description : Board-side signal bundle of the LED sequencer.
// Ports       : i_mode [1:0]     - display mode (async board switches)
//               i_sel [SEL_W-1:0] - channel select for SINGLE mode (async)
//               o_led [NUM_CH-1:0]- registered LED drive
//               o_tick           - one-cycle LFSR period pulse
//               modport master : board/testbench side
//               modport slave  : sequencer side
// Revision    : 1.0 - initial release
// ============================================================================
interface lfsr_led_sequencer_if #(
    parameter int NUM_CH = 4,
    parameter int SEL_W  = $clog2(NUM_CH)
);
    logic [1:0]        i_mode;
    logic [SEL_W-1:0]  i_sel;
    logic [NUM_CH-1:0] o_led;
    logic              o_tick;

    modport master (output i_mode, output i_sel, input  o_led, input  o_tick);
    modport slave  (input  i_mode, input  i_sel, output o_led, output o_tick);
endinterface : lfsr_led_sequencer_if
`default_nettype wire

// File: rtl/lfsr_xnor.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_xnor
// Description : Free-running Fibonacci LFSR with XNOR feedback. Resets to
//               zero and walks the full 2^WIDTH-1 cycle.
// Ports       : i_clk   - system clock
//               i_rst_n - asynchronous active-low reset
//               o_data  - current LFSR contents
//               o_done  - high when the next state is zero (period wrap),
//                         intended to be registered by the consumer
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_xnor
    import lfsr_pkg::*;
#(
    parameter int WIDTH = 22
) (
    input  wire logic             i_clk,
    input  wire logic             i_rst_n,
    output logic      [WIDTH-1:0] o_data,
    output logic                  o_done
);

    localparam logic [WIDTH-1:0] C_TAPS = WIDTH'(lfsr_taps(WIDTH));

    logic [WIDTH-1:0] r_data;
    logic             w_fb;
    logic [WIDTH-1:0] w_next;

    assign w_fb   = ~^(r_data & C_TAPS);
    assign w_next = {r_data[WIDTH-2:0], w_fb};

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_data <= '0;
        end else begin
            r_data <= w_next;
        end
    end

    // Flagging the upcoming zero lets a downstream register line its pulse
    // up with the cycle in which the LFSR itself reads zero.
    assign o_done = (w_next == '0);
    assign o_data = r_data;

endmodule : lfsr_xnor
`default_nettype wire

// File: rtl/lfsr_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : lfsr_led_sequencer
// Description : LFSR-paced LED driver. A period tick advances a toggle bit,
//               a chase position and a counter; the synchronised mode input
//               selects which of these is shown on the LEDs.
// Ports       : i_clk   - system clock
//               i_rst_n - asynchronous active-low reset
//               bus     - lfsr_led_sequencer_if.slave (i_mode, i_sel in;
//                         o_led, o_tick out, all outputs registered)
// Revision    : 1.0 - initial release
// ============================================================================
module lfsr_led_sequencer
    import lfsr_pkg::*;
#(
    parameter int LFSR_WIDTH = 22,
    parameter int NUM_CH     = 4,
    parameter int SEL_W      = $clog2(NUM_CH)
) (
    input  wire logic           i_clk,
    input  wire logic           i_rst_n,
    lfsr_led_sequencer_if.slave bus
);

    logic [LFSR_WIDTH-1:0] w_lfsr_data;
    logic                  w_lfsr_done;

    lfsr_xnor #(
        .WIDTH (LFSR_WIDTH)
    ) u_lfsr (
        .i_clk   (i_clk),
        .i_rst_n (i_rst_n),
        .o_data  (w_lfsr_data),
        .o_done  (w_lfsr_done)
    );

    // Contents are not needed here; only the period wrap matters.
    logic w_lfsr_unused;
    assign w_lfsr_unused = ^w_lfsr_data;

    logic [1:0]        r_mode_meta, r_mode_s;
    logic [SEL_W-1:0]  r_sel_meta,  r_sel_s;
    logic              r_tick;
    logic              r_toggle;
    logic [SEL_W-1:0]  r_pos;
    logic [NUM_CH-1:0] r_count;
    logic [NUM_CH-1:0] r_led;

    logic              w_toggle_nxt;
    logic [SEL_W-1:0]  w_pos_nxt;
    logic [NUM_CH-1:0] w_count_nxt;
    logic [NUM_CH-1:0] w_led_nxt;

    // NUM_CH is a power of two, so natural SEL_W-bit overflow is the wrap.
    assign w_toggle_nxt = r_tick ? ~r_toggle               : r_toggle;
    assign w_pos_nxt    = r_tick ? r_pos + SEL_W'(1)       : r_pos;
    assign w_count_nxt  = r_tick ? r_count + NUM_CH'(1)    : r_count;

    // LEDs are driven from the post-tick values so they change on the same
    // edge as the state they display.
    always_comb begin
        w_led_nxt = '0;
        case (r_mode_s)
            MODE_SINGLE: w_led_nxt[r_sel_s]   = w_toggle_nxt;
            MODE_ALL:    w_led_nxt            = {NUM_CH{w_toggle_nxt}};
            MODE_CHASE:  w_led_nxt[w_pos_nxt] = 1'b1;
            default:     w_led_nxt            = w_count_nxt;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            r_mode_meta <= '0;
            r_mode_s    <= '0;
            r_sel_meta  <= '0;
            r_sel_s     <= '0;
            r_tick      <= 1'b0;
            r_toggle    <= 1'b0;
            r_pos       <= '0;
            r_count     <= '0;
            r_led       <= '0;
        end else begin
            r_mode_meta <= bus.i_mode;
            r_mode_s    <= r_mode_meta;
            r_sel_meta  <= bus.i_sel;
            r_sel_s     <= r_sel_meta;
            r_tick      <= w_lfsr_done;
            r_toggle    <= w_toggle_nxt;
            r_pos       <= w_pos_nxt;
            r_count     <= w_count_nxt;
            r_led       <= w_led_nxt;
        end
    end

    assign bus.o_led  = r_led;
    assign bus.o_tick = r_tick;

endmodule : lfsr_led_sequencer
`default_nettype wire

// File: tb/tb_lfsr_led_sequencer.sv
`default_nettype none
// ============================================================================
// Module      : tb_lfsr_led_sequencer
// Description : Directed self-checking bench, LFSR_WIDTH=4 (period 15),
//               NUM_CH=4.
// Revision    : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_lfsr_led_sequencer;

    logic clk;
    logic rst_n;
    int   n_tests;
    int   n_fail;

    lfsr_led_sequencer_if #(.NUM_CH(4)) bus ();

    lfsr_led_sequencer #(
        .LFSR_WIDTH (4),
        .NUM_CH     (4)
    ) dut (
        .i_clk   (clk),
        .i_rst_n (rst_n),
        .bus     (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        if (obs !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Steps edges until o_tick is seen high; bounded at 40 edges.
    task automatic wait_for_tick(output int n, output logic [3:0] led_or);
        n      = 0;
        led_or = 4'b0;
        do begin
            step();
            n++;
            led_or |= bus.o_led;
        end while (!bus.o_tick && n < 40);
    endtask

    task automatic do_reset(input logic [1:0] mode);
        @(negedge clk);
        rst_n      = 1'b0;
        bus.i_mode = mode;
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    int         n;
    logic [3:0] led_or;
    logic [3:0] chase_exp [5];
    logic [3:0] exp_cnt;

    initial begin
        n_tests = 0;
        n_fail  = 0;
        chase_exp[0] = 4'b0010;
        chase_exp[1] = 4'b0100;
        chase_exp[2] = 4'b1000;
        chase_exp[3] = 4'b0001;
        chase_exp[4] = 4'b0010;

        // Reset and period, mode ALL
        rst_n      = 1'b0;
        bus.i_mode = 2'b01;
        bus.i_sel  = 2'd0;
        #23;
        check_eq("reset_led", 32'(bus.o_led), 32'h0);
        check_eq("reset_tick", 32'(bus.o_tick), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for_tick(n, led_or);
        check_eq("first_tick_edges", n, 15);
        check_eq("led_zero_before_tick", 32'(led_or), 32'h0);
        step();
        check_eq("tick_not_consecutive", 32'(bus.o_tick), 32'h0);
        check_eq("all_tick1", 32'(bus.o_led), 32'hF);
        wait_for_tick(n, led_or);
        check_eq("period_2", n, 14);
        step();
        check_eq("all_tick2", 32'(bus.o_led), 32'h0);

        // SINGLE, sel=2
        bus.i_mode = 2'b00;
        bus.i_sel  = 2'd2;
        wait_for_tick(n, led_or);
        check_eq("period_3", n, 14);
        check_eq("single_pre_tick3", 32'(bus.o_led), 32'h0);
        step();
        check_eq("single_tick3", 32'(bus.o_led), 32'b0100);
        wait_for_tick(n, led_or);
        step();
        check_eq("single_tick4", 32'(bus.o_led), 32'b0000);
        wait_for_tick(n, led_or);
        step();
        check_eq("single_tick5", 32'(bus.o_led), 32'b0100);
        bus.i_sel = 2'd0;
        step();
        step();
        check_eq("sel_latency_edge2", 32'(bus.o_led), 32'b0100);
        step();
        check_eq("sel_latency_edge3", 32'(bus.o_led), 32'b0001);

        // CHASE wrap from fresh reset
        do_reset(2'b10);
        for (int k = 0; k < 5; k++) begin
            wait_for_tick(n, led_or);
            if (k == 0) begin
                check_eq("chase_period", n, 15);
                check_eq("chase_pre_tick", 32'(bus.o_led), 32'b0001);
            end
            step();
            check_eq($sformatf("chase_tick%0d", k + 1), 32'(bus.o_led), 32'(chase_exp[k]));
        end

        // COUNT wrap from fresh reset
        do_reset(2'b11);
        for (int k = 1; k <= 17; k++) begin
            wait_for_tick(n, led_or);
            step();
            exp_cnt = (k == 1)  ? 4'b0001 :
                      (k == 15) ? 4'b1111 :
                      (k == 16) ? 4'b0000 :
                      (k == 17) ? 4'b0001 : 4'(k);
            if (k == 1 || k >= 15)
                check_eq($sformatf("count_tick%0d", k), 32'(bus.o_led), 32'(exp_cnt));
        end

        // Mode change landing in the same cycle as a tick
        do_reset(2'b01);
        wait_for_tick(n, led_or);
        step();
        check_eq("simul_all_tick1", 32'(bus.o_led), 32'hF);
        repeat (12) step();
        bus.i_mode = 2'b10;
        step();
        check_eq("simul_pre_sync", 32'(bus.o_led), 32'hF);
        step();
        check_eq("simul_tick_high", 32'(bus.o_tick), 32'h1);
        check_eq("simul_tick_cycle_led", 32'(bus.o_led), 32'hF);
        step();
        check_eq("simul_chase_pos2", 32'(bus.o_led), 32'b0100);

        // Reset mid-period in COUNT mode
        do_reset(2'b11);
        wait_for_tick(n, led_or);
        step();
        check_eq("midrst_count1", 32'(bus.o_led), 32'b0001);
        wait_for_tick(n, led_or);
        step();
        check_eq("midrst_count2", 32'(bus.o_led), 32'b0010);
        repeat (6) step();
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("midrst_async_led", 32'(bus.o_led), 32'h0);
        check_eq("midrst_async_tick", 32'(bus.o_tick), 32'h0);
        @(negedge clk);
        @(negedge clk);
        rst_n = 1'b1;
        wait_for_tick(n, led_or);
        check_eq("midrst_period", n, 15);
        step();
        check_eq("midrst_count_restart", 32'(bus.o_led), 32'b0001);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule : tb_lfsr_led_sequencer
`default_nettype wire
